// File: rtl/lcd_timing_gen.sv
// LCD panel scan timing: sync/DE generation, one-cycle-early pixel coordinates,
// RGB forwarding, PWM backlight and frame start/count reporting.
module lcd_timing_gen #(
  parameter logic [10:0] H_SYNC  = 11'd41,
  parameter logic [10:0] H_BACK  = 11'd2,
  parameter logic [10:0] H_DISP  = 11'd480,
  parameter logic [10:0] H_FRONT = 11'd2,
  parameter logic [10:0] V_SYNC  = 11'd10,
  parameter logic [10:0] V_BACK  = 11'd2,
  parameter logic [10:0] V_DISP  = 11'd272,
  parameter logic [10:0] V_FRONT = 11'd2,
  parameter logic        HS_POL  = 1'b0,
  parameter logic        VS_POL  = 1'b0,
  parameter logic [8:0]  BL_DUTY = 9'd256
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        lcd_en,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] H_DE_BEG  = H_SYNC + H_BACK;
  localparam logic [10:0] H_DE_END  = H_DE_BEG + H_DISP;
  localparam logic [10:0] H_REQ_BEG = H_DE_BEG - 11'd1;
  localparam logic [10:0] H_REQ_END = H_DE_END - 11'd1;
  localparam logic [10:0] V_ACT_BEG = V_SYNC + V_BACK;
  localparam logic [10:0] V_ACT_END = V_ACT_BEG + V_DISP;

  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [7:0]  r_pwm_cnt;
  logic        r_frame_start;
  logic [15:0] r_frame_cnt;
  logic        r_seen_frame;

  logic        w_v_act;
  logic        w_data_req;
  logic        w_de;
  logic        w_frame_begin;

  // Disabled scan parks both counters at the frame origin.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!lcd_en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_TOTAL - 11'd1) begin
      r_h_cnt <= '0;
      if (r_v_cnt == V_TOTAL - 11'd1) begin
        r_v_cnt <= '0;
      end else begin
        r_v_cnt <= r_v_cnt + 11'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // The origin cycle covers both the v wrap and a fresh start after enable/reset.
  assign w_frame_begin = lcd_en && (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
      r_seen_frame  <= 1'b0;
    end else begin
      r_frame_start <= w_frame_begin;
      if (w_frame_begin) begin
        r_seen_frame <= 1'b1;
        if (r_seen_frame) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  always_comb begin
    w_v_act    = (r_v_cnt >= V_ACT_BEG) && (r_v_cnt < V_ACT_END);
    w_data_req = lcd_en && w_v_act && (r_h_cnt >= H_REQ_BEG) && (r_h_cnt < H_REQ_END);
    w_de       = lcd_en && w_v_act && (r_h_cnt >= H_DE_BEG) && (r_h_cnt < H_DE_END);
  end

  // Coordinates lead DE by one cycle to match the registered pixel source.
  assign pixel_xpos  = w_data_req ? (r_h_cnt - H_REQ_BEG) : 11'd0;
  assign pixel_ypos  = w_data_req ? (r_v_cnt - V_ACT_BEG) : 11'd0;
  assign lcd_de      = w_de;
  assign lcd_rgb     = w_de ? pixel_data : 24'h000000;
  assign lcd_hs      = (lcd_en && (r_h_cnt < H_SYNC)) ? HS_POL : ~HS_POL;
  assign lcd_vs      = (lcd_en && (r_v_cnt < V_SYNC)) ? VS_POL : ~VS_POL;
  assign lcd_bl      = ({1'b0, r_pwm_cnt} < BL_DUTY);
  assign h_disp      = H_DISP;
  assign v_disp      = V_DISP;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen on a reduced 15x8 raster plus two
// backlight-extreme instances.
module tb_lcd_timing_gen;

  logic        lcd_pclk = 1'b0;
  logic        rst_n;
  logic        lcd_en;
  logic [23:0] pixel_data;

  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic        lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start;
  logic [23:0] lcd_rgb;
  logic [15:0] frame_cnt;

  logic [10:0] z0_x, z0_y, z0_hd, z0_vd, z1_x, z1_y, z1_hd, z1_vd;
  logic        z0_hs, z0_vs, z0_de, z0_bl, z0_fs, z1_hs, z1_vs, z1_de, z1_bl, z1_fs;
  logic [23:0] z0_rgb, z1_rgb;
  logic [15:0] z0_fc, z1_fc;

  lcd_timing_gen #(
    .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
    .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BL_DUTY(9'd64)
  ) dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .lcd_en(lcd_en), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .h_disp(h_disp), .v_disp(v_disp),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .lcd_bl(lcd_bl), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  lcd_timing_gen #(
    .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
    .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1),
    .BL_DUTY(9'd0)
  ) dut_bl0 (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .lcd_en(lcd_en), .pixel_data(pixel_data),
    .pixel_xpos(z0_x), .pixel_ypos(z0_y), .h_disp(z0_hd), .v_disp(z0_vd),
    .lcd_hs(z0_hs), .lcd_vs(z0_vs), .lcd_de(z0_de), .lcd_rgb(z0_rgb),
    .lcd_bl(z0_bl), .frame_start(z0_fs), .frame_cnt(z0_fc)
  );

  lcd_timing_gen #(
    .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
    .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1),
    .BL_DUTY(9'd256)
  ) dut_bl256 (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .lcd_en(lcd_en), .pixel_data(pixel_data),
    .pixel_xpos(z1_x), .pixel_ypos(z1_y), .h_disp(z1_hd), .v_disp(z1_vd),
    .lcd_hs(z1_hs), .lcd_vs(z1_vs), .lcd_de(z1_de), .lcd_rgb(z1_rgb),
    .lcd_bl(z1_bl), .frame_start(z1_fs), .frame_cnt(z1_fc)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  typedef struct {
    logic        hs, vs, de, bl, fs;
    logic [10:0] x, y;
    logic [23:0] rgb;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec, n_err;
  int          m_t, m_pwm, cyc, de_cnt, bl_cnt;
  logic        m_fs, m_seen;
  logic [15:0] m_cnt;
  logic [10:0] prev_ex, prev_ey, obs_x, obs_y;
  int          fs_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One pixel clock: advance model at the edge, drive, expect, compare at negedge.
  task automatic step(input logic en_new);
    exp_t e;
    exp_t g;
    int   h, v;
    logic fs_next, vact, req;
    @(posedge lcd_pclk);
    #1;
    fs_next = lcd_en && (m_t == 0);
    if (fs_next && m_seen) m_cnt = m_cnt + 16'd1;
    if (fs_next) m_seen = 1'b1;
    m_fs  = fs_next;
    m_t   = lcd_en ? (m_t + 1) % 120 : 0;
    m_pwm = (m_pwm + 1) % 256;
    cyc++;
    lcd_en     = en_new;
    pixel_data = {1'b0, obs_x, 1'b0, obs_y};
    h    = m_t % 15;
    v    = m_t / 15;
    vact = (v >= 3) && (v < 7);
    req  = en_new && vact && (h >= 4) && (h < 12);
    e.de  = en_new && vact && (h >= 5) && (h < 13);
    e.x   = req ? 11'(h - 4) : 11'd0;
    e.y   = req ? 11'(v - 3) : 11'd0;
    e.hs  = !(en_new && (h < 2));
    e.vs  = !(en_new && (v < 1));
    e.rgb = e.de ? {1'b0, prev_ex, 1'b0, prev_ey} : 24'h0;
    e.bl  = (m_pwm < 64);
    e.fs  = m_fs;
    e.cnt = m_cnt;
    prev_ex = e.x;
    prev_ey = e.y;
    sb_q.push_back(e);
    @(negedge lcd_pclk);
    g = sb_q.pop_front();
    chk("hs", lcd_hs, g.hs);
    chk("vs", lcd_vs, g.vs);
    chk("de", lcd_de, g.de);
    chk("xpos", pixel_xpos, g.x);
    chk("ypos", pixel_ypos, g.y);
    chk("rgb", lcd_rgb, g.rgb);
    chk("bl64", lcd_bl, g.bl);
    chk("frame_start", frame_start, g.fs);
    chk("frame_cnt", frame_cnt, g.cnt);
    chk("bl0", z0_bl, 1'b0);
    chk("bl256", z1_bl, 1'b1);
    $display("cyc %0d en=%0b hs=%0b vs=%0b de=%0b x=%0d y=%0d rgb=%06h bl=%0b fs=%0b fc=%0d",
             cyc, lcd_en, lcd_hs, lcd_vs, lcd_de, pixel_xpos, pixel_ypos, lcd_rgb,
             lcd_bl, frame_start, frame_cnt);
    obs_x = pixel_xpos;
    obs_y = pixel_ypos;
    if (lcd_de) de_cnt++;
    if (lcd_bl) bl_cnt++;
    if (frame_start) fs_cyc.push_back(cyc);
  endtask

  // Asynchronous reset entered between edges; outputs must clear before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_hs", lcd_hs, 1'b0);
    chk("rst_vs", lcd_vs, 1'b0);
    chk("rst_de", lcd_de, 1'b0);
    chk("rst_xpos", pixel_xpos, 11'd0);
    chk("rst_ypos", pixel_ypos, 11'd0);
    chk("rst_rgb", lcd_rgb, 24'h0);
    chk("rst_bl", lcd_bl, 1'b1);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_fcnt", frame_cnt, 16'd0);
    chk("h_disp", h_disp, 11'd8);
    chk("v_disp", v_disp, 11'd4);
    m_t = 0; m_pwm = 0; m_fs = 1'b0; m_seen = 1'b0; m_cnt = 16'd0;
    prev_ex = 11'd0; prev_ey = 11'd0; cyc = 0;
    repeat (2) @(negedge lcd_pclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    n_vec = 0; n_err = 0; de_cnt = 0; bl_cnt = 0;
    obs_x = 11'd0; obs_y = 11'd0;
    rst_n = 1'b1; lcd_en = 1'b1; pixel_data = 24'h0;
    @(negedge lcd_pclk);
    do_reset();

    repeat (120) step(1'b1);
    chk("de_per_frame", de_cnt, 32);
    repeat (130) step(1'b1);
    chk("fs_pulses", fs_cyc.size(), 3);
    if (fs_cyc.size() >= 3) begin
      chk("fs_cyc0", fs_cyc[0], 1);
      chk("fs_cyc1", fs_cyc[1], 121);
      chk("fs_cyc2", fs_cyc[2], 241);
    end

    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    m_cnt = 16'hFFFF;
    repeat (130) step(1'b1);
    chk("fcnt_wrap", frame_cnt, 16'd0);

    guard = 0;
    while (m_t != 66 && guard < 200) begin
      step(1'b1);
      guard++;
    end
    repeat (5) step(1'b0);
    repeat (260) step(1'b1);

    do_reset();
    bl_cnt = 0;
    repeat (256) step(1'b1);
    chk("bl_high_per_period", bl_cnt, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
